// File: rtl/uart_tx_controller_pkg.sv
// Shared UART transmit definitions: FSM state encoding, default bit period, parity modes.
package uart_tx_controller_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;
    localparam int unsigned PAR_MODE_EVEN        = 0;
    localparam int unsigned PAR_MODE_ODD         = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_controller_if.sv
// Host-side handshake between a word producer and the UART transmitter.
interface uart_tx_controller_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 start;
    logic [DATA_BITS-1:0] data_in;
    logic                 busy;
    logic                 done;

    modport master (output start, data_in, input busy, done);
    modport slave  (input start, data_in, output busy, done);
endinterface

// File: rtl/uart_tx_controller_baud.sv
// Bit-period counter: tick is high in the last cycle of each bit period.
module uart_tx_controller_baud
    import uart_tx_controller_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_tick;
    logic [CNT_W-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count + CNT_W'(1);
        if (clear || (r_count == LAST)) begin
            w_count_next = '0;
        end
    end

    // Tick is registered alongside the count so it always equals (r_count == LAST).
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_tick  <= (w_count_next == LAST);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmitter: latches a word on start, serialises start/data(LSB first)/parity/stop on tx.
module uart_tx_controller
    import uart_tx_controller_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = PAR_MODE_EVEN,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_tx_controller_if.slave  bus,
    output logic                 tx
);

    localparam int unsigned       IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_BITS - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_e            r_state;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_parity;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;

    logic w_tick;
    logic w_clear;
    logic w_accept;

    // Counter held at zero while idle so the start bit gets a full period.
    assign w_clear  = (r_state == ST_IDLE);
    assign w_accept = bus.start && !r_busy;

    uart_tx_controller_baud #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock (clock),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_parity   <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_shreg  <= bus.data_in;
                        r_parity <= (^bus.data_in) ^ 1'(PARITY_ODD);
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state   <= ST_DATA;
                        r_tx      <= r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                        r_bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state    <= ST_STOP;
                                r_tx       <= 1'b1;
                                r_stop_idx <= 1'b0;
                            end
                        end else begin
                            r_tx      <= r_shreg[0];
                            r_shreg   <= r_shreg >> 1;
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state    <= ST_STOP;
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_stop_idx == LAST_STOP) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller: three instances cover even/odd parity and no-parity/2-stop.
`timescale 1ns/1ps
module tb_uart_tx_controller;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    logic       start_v [3];
    logic [7:0] data_v  [3];
    logic       tx_v    [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       tx_a, tx_b, tx_c;

    uart_tx_controller_if #(.DATA_BITS(8)) if_a ();
    uart_tx_controller_if #(.DATA_BITS(8)) if_b ();
    uart_tx_controller_if #(.DATA_BITS(8)) if_c ();

    assign if_a.start   = start_v[0];
    assign if_a.data_in = data_v[0];
    assign if_b.start   = start_v[1];
    assign if_b.data_in = data_v[1];
    assign if_c.start   = start_v[2];
    assign if_c.data_in = data_v[2];
    assign tx_v[0]   = tx_a;
    assign tx_v[1]   = tx_b;
    assign tx_v[2]   = tx_c;
    assign busy_v[0] = if_a.busy;
    assign busy_v[1] = if_b.busy;
    assign busy_v[2] = if_c.busy;
    assign done_v[0] = if_a.done;
    assign done_v[1] = if_b.done;
    assign done_v[2] = if_c.done;

    uart_tx_controller #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        dut_a (.clock(clock), .reset(reset), .bus(if_a), .tx(tx_a));
    uart_tx_controller #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        dut_b (.clock(clock), .reset(reset), .bus(if_b), .tx(tx_b));
    uart_tx_controller #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        dut_c (.clock(clock), .reset(reset), .bus(if_c), .tx(tx_c));

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // exp lists the 11 line bits in transmit order, leftmost first.
    // mode 0: plain frame; 1: start held high, data_in switched to alt; 2: start poked mid-frame with alt.
    task automatic frame(input int sel, input logic [7:0] data, input logic [10:0] exp,
                         input int mode, input logic [7:0] alt);
        start_v[sel] = 1'b1;
        data_v[sel]  = data;
        step();
        if (mode == 1) data_v[sel] = alt;
        else           start_v[sel] = 1'b0;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("dut%0d d%02h bit%0d cyc%0d tx", sel, data, b, c), tx_v[sel], exp[10-b]);
                chk($sformatf("dut%0d d%02h bit%0d cyc%0d busy", sel, data, b, c), busy_v[sel], 1'b1);
                chk($sformatf("dut%0d d%02h bit%0d cyc%0d done", sel, data, b, c), done_v[sel], 1'b0);
                if (mode == 2) begin
                    if (b == 5 && c == 2) begin
                        start_v[sel] = 1'b1;
                        data_v[sel]  = alt;
                    end else begin
                        start_v[sel] = 1'b0;
                    end
                end
                step();
            end
        end
        chk($sformatf("dut%0d d%02h end busy", sel, data), busy_v[sel], 1'b0);
        chk($sformatf("dut%0d d%02h end done", sel, data), done_v[sel], 1'b1);
        chk($sformatf("dut%0d d%02h end tx", sel, data), tx_v[sel], 1'b1);
        if (mode != 1) begin
            step();
            chk($sformatf("dut%0d d%02h idle done", sel, data), done_v[sel], 1'b0);
            chk($sformatf("dut%0d d%02h idle busy", sel, data), busy_v[sel], 1'b0);
            chk($sformatf("dut%0d d%02h idle tx", sel, data), tx_v[sel], 1'b1);
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            data_v[i]  = 8'h00;
        end
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset dut%0d tx", i), tx_v[i], 1'b1);
            chk($sformatf("reset dut%0d busy", i), busy_v[i], 1'b0);
            chk($sformatf("reset dut%0d done", i), done_v[i], 1'b0);
        end
        reset = 1'b1;
        step();

        // 0x55 even parity
        frame(0, 8'h55, 11'b0_10101010_0_1, 0, 8'h00);
        // 0x00 odd parity
        frame(1, 8'h00, 11'b0_00000000_1_1, 0, 8'h00);
        // back-to-back 0xA3 then 0x3C with start held high
        frame(0, 8'hA3, 11'b0_11000101_0_1, 1, 8'h3C);
        frame(0, 8'h3C, 11'b0_00111100_0_1, 0, 8'h00);
        // start poked mid-frame with 0x00 must not disturb 0x97
        frame(0, 8'h97, 11'b0_11101001_1_1, 2, 8'h00);

        // reset during data bit 3 of 0xF0 (bit3 = 0)
        start_v[0] = 1'b1;
        data_v[0]  = 8'hF0;
        step();
        start_v[0] = 1'b0;
        repeat (17) step();
        chk("pre-reset tx", tx_v[0], 1'b0);
        chk("pre-reset busy", busy_v[0], 1'b1);
        reset = 1'b0;
        step();
        chk("mid-reset tx", tx_v[0], 1'b1);
        chk("mid-reset busy", busy_v[0], 1'b0);
        chk("mid-reset done", done_v[0], 1'b0);
        reset = 1'b1;
        step();
        chk("post-reset tx", tx_v[0], 1'b1);
        chk("post-reset busy", busy_v[0], 1'b0);
        frame(0, 8'hA3, 11'b0_11000101_0_1, 0, 8'h00);

        // no parity, two stop bits
        frame(2, 8'hFF, 11'b0_11111111_1_1, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
